echo_delay: RTL and testbench

Parametrised, RAM-based multi-channel delay/echo effect for the SoundMixer audio path. It replaces the fixed 4096-tap register chain with a circular buffer. The delay length is set at run time in frames. Three modes are supported: bypass, feed-forward delay and saturating feedback echo. Channels arrive interleaved on one sample strobe, and the block sits between the mixer input stage and the output formatter.

---
 rtl/echo_delay.sv | 177 +++++++++++++++++
 tb/tb_echo_delay.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay.sv
`default_nettype none
// ============================================================================
// Module      : echo_delay
// Description : RAM-backed multi-channel delay / feedback echo (bypass, FF, FB)
// Revision    : 1.0
// ============================================================================
module echo_delay #(
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 12,
    parameter int CH_W   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              wren,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [1:0]        mode,
    input  logic [2:0]        fb_shift,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_chan
);

    localparam int RAM_AW = ADDR_W + CH_W;
    localparam int NWORDS = 2 ** RAM_AW;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [RAM_AW-1:0]   clear_addr;
    logic [CH_W-1:0]     chan;
    logic [ADDR_W-1:0]   wp;
    logic                accept;

    logic [ADDR_W-1:0]   dly;
    logic [ADDR_W-1:0]   rd_frame;
    logic [RAM_AW-1:0]   rd_addr;
    logic [WIDTH-1:0]    rd_q;

    logic                s1_valid;
    logic [WIDTH-1:0]    s1_x;
    logic [CH_W-1:0]     s1_chan;
    logic [RAM_AW-1:0]   s1_addr;
    logic [1:0]          s1_mode;
    logic [2:0]          s1_shift;

    logic signed [WIDTH-1:0] x_s;
    logic signed [WIDTH-1:0] y_s;
    logic signed [WIDTH-1:0] y_att;
    logic [2:0]              shift_amt;
    logic [WIDTH:0]          fb_sum;
    logic [WIDTH-1:0]        fb_sat;
    logic [WIDTH-1:0]        ff_out;
    logic [WIDTH-1:0]        proc_out;
    logic [WIDTH-1:0]        proc_wdata;

    logic                mem_we;
    logic [RAM_AW-1:0]   mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [WIDTH-1:0]    mem [0:NWORDS-1];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clear_addr == {RAM_AW{1'b1}}) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    assign accept   = wren && in_ready;
    assign dly      = (delay_len == '0) ? ADDR_W'(1) : delay_len;
    assign rd_frame = wp - dly;
    assign rd_addr  = {rd_frame, chan};

    // ---------------- datapath arithmetic ----------------
    assign x_s       = s1_x;
    assign y_s       = rd_q;
    assign shift_amt = (s1_shift == 3'd0) ? 3'd1 : s1_shift;
    assign y_att     = y_s >>> shift_amt;
    assign fb_sum    = {x_s[WIDTH-1], x_s} + {y_att[WIDTH-1], y_att};
    assign ff_out    = (x_s >>> 1) + (y_s >>> 1);

    // Top two bits of the widened sum disagree only on overflow.
    always_comb begin
        if (fb_sum[WIDTH] != fb_sum[WIDTH-1]) begin
            fb_sat = fb_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fb_sat = fb_sum[WIDTH-1:0];
        end
    end

    always_comb begin
        proc_out   = s1_x;
        proc_wdata = s1_x;
        case (s1_mode)
            2'b01: proc_out = ff_out;
            2'b10: begin
                proc_out   = fb_sat;
                proc_wdata = fb_sat;
            end
            default: begin
                proc_out   = s1_x;
                proc_wdata = s1_x;
            end
        endcase
    end

    // ---------------- delay RAM ----------------
    assign mem_we    = reset && ((state == ST_CLEAR) || s1_valid);
    assign mem_addr  = (state == ST_CLEAR) ? clear_addr : s1_addr;
    assign mem_wdata = (state == ST_CLEAR) ? '0 : proc_wdata;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_q <= mem[rd_addr];
    end

    // ---------------- pipeline and counters ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            clear_addr <= '0;
            chan       <= '0;
            wp         <= '0;
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
        end else begin
            if (state == ST_CLEAR) begin
                clear_addr <= clear_addr + 1'b1;
            end
            s1_valid <= accept;
            if (accept) begin
                s1_x     <= in_data;
                s1_chan  <= chan;
                s1_addr  <= {wp, chan};
                s1_mode  <= mode;
                s1_shift <= fb_shift;
                chan     <= chan + 1'b1;
                if (chan == {CH_W{1'b1}}) begin
                    wp <= wp + 1'b1;
                end
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= proc_out;
                out_chan <= s1_chan;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_delay
// Description : Directed bench for echo_delay with a frame-history reference model
// Revision    : 1.0
// ============================================================================
module tb_echo_delay;

    localparam int NW  = 32;
    localparam int CHN = 2;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        wren      = 1'b0;
    logic [23:0] in_data   = '0;
    logic [3:0]  delay_len = '0;
    logic [1:0]  mode      = '0;
    logic [2:0]  fb_shift  = '0;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_chan;

    echo_delay #(.WIDTH(24), .ADDR_W(4), .CH_W(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .wren      (wren),
        .in_ready  (in_ready),
        .delay_len (delay_len),
        .mode      (mode),
        .fb_shift  (fb_shift),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        int          ch;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total   = 0;
    int          bad     = 0;
    int          cyc     = 0;
    int          clr_cnt = 0;
    bit          started = 1'b0;
    logic [23:0] hist [0:1][0:1023];
    int          mframe  = 0;
    int          mchan   = 0;
    logic [23:0] log_d[$];
    int          log_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [23:0] lg(input int i);
        if (i < log_d.size()) return log_d[i];
        return 24'hxxxxxx;
    endfunction

    function automatic int lgc(input int i);
        if (i < log_c.size()) return log_c[i];
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int f = 0; f < 1024; f++)
                hist[c][f] = '0;
        mframe = 0;
        mchan  = 0;
    endtask

    // Each channel keeps its full written history; the buffer slot d frames back
    // always still holds the value written at that frame because d < depth.
    task automatic model_push(input logic [23:0] x);
        int d, s, xi, yi, o, wv;
        d  = (delay_len == 0) ? 1 : int'(delay_len);
        s  = (fb_shift == 0) ? 1 : int'(fb_shift);
        xi = $signed(x);
        yi = 0;
        if (mframe >= d) yi = $signed(hist[mchan][mframe-d]);
        case (mode)
            2'b01: begin o = (xi >>> 1) + (yi >>> 1); wv = xi; end
            2'b10: begin
                o = xi + (yi >>> s);
                if (o > 8388607)  o = 8388607;
                if (o < -8388608) o = -8388608;
                wv = o;
            end
            default: begin o = xi; wv = xi; end
        endcase
        hist[mchan][mframe] = wv[23:0];
        q.push_back('{o[23:0], mchan, cyc + 2});
        mchan++;
        if (mchan == CHN) begin
            mchan = 0;
            mframe++;
        end
    endtask

    task automatic cycle(input bit wr, input logic [23:0] x, input bit rst);
        reset   = rst;
        wren    = wr;
        in_data = x;
        if (!rst) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            model_reset();
        end else if (wr && clr_cnt == NW) begin
            model_push(x);
        end
        @(posedge clk);
        cyc++;
        if (!rst) begin
            clr_cnt = 0;
            started = 1'b1;
        end else if (clr_cnt < NW) begin
            clr_cnt++;
        end
        #2;
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 100 && clr_cnt < NW; i++) cycle(1'b0, '0, 1'b1);
        log_d.delete();
        log_c.delete();
    endtask

    task automatic drain();
        repeat (3) cycle(1'b0, '0, 1'b1);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("in_ready", {31'd0, in_ready}, {31'd0, clr_cnt == NW});
                if (q.size() > 0 && q[0].due == cyc) begin
                    chk("out_valid", {31'd0, out_valid}, 32'd1);
                    chk("out_data", {8'd0, out_data}, {8'd0, q[0].d});
                    chk("out_chan", {31'd0, out_chan}, q[0].ch);
                    void'(q.pop_front());
                end else begin
                    chk("out_valid_idle", {31'd0, out_valid}, 32'd0);
                end
                if (out_valid) begin
                    log_d.push_back(out_data);
                    log_c.push_back(int'(out_chan));
                end
            end
        end
    end

    initial begin
        int zc;
        int n0;
        model_reset();

        // Reset held three cycles, then count clear cycles
        repeat (3) cycle(1'b0, '0, 1'b0);
        zc = 0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) break;
            zc++;
            cycle(1'b0, '0, 1'b1);
        end
        chk("clear_len", zc, 32);
        log_d.delete();
        log_c.delete();
        mode = 2'b01; delay_len = 4'd3;
        repeat (4) cycle(1'b1, 24'h000100, 1'b1);
        drain();
        for (int i = 0; i < 4; i++) chk("cleared_buf", {8'd0, lg(i)}, 32'h80);

        // Feed-forward impulse, delay 3
        do_reset();
        mode = 2'b01; delay_len = 4'd3;
        for (int f = 0; f < 8; f++) begin
            cycle(1'b1, (f == 0) ? 24'h400000 : 24'h0, 1'b1);
            cycle(1'b1, 24'h0, 1'b1);
        end
        drain();
        for (int i = 0; i < 16; i++) begin
            chk("ff_impulse", {8'd0, lg(i)}, (i == 0 || i == 6) ? 32'h200000 : 32'h0);
            chk("ff_chan", lgc(i), i % 2);
        end

        // Feedback echo on ch1, delay 2, shift 1
        do_reset();
        mode = 2'b10; delay_len = 4'd2; fb_shift = 3'd1;
        for (int f = 0; f < 8; f++) begin
            cycle(1'b1, 24'h0, 1'b1);
            cycle(1'b1, (f == 0) ? 24'h400000 : 24'h0, 1'b1);
        end
        drain();
        for (int f = 0; f < 8; f++) begin
            chk("fb_ch1", {8'd0, lg(2*f+1)}, (f % 2 == 0) ? (32'h400000 >> (f/2)) : 32'h0);
            chk("fb_ch0", {8'd0, lg(2*f)}, 32'h0);
        end

        // Saturation at both rails
        for (int k = 0; k < 2; k++) begin
            logic [23:0] v;
            v = (k == 0) ? 24'h7FFFFF : 24'h800000;
            do_reset();
            mode = 2'b10; delay_len = 4'd1; fb_shift = 3'd1;
            for (int f = 0; f < 6; f++) begin
                cycle(1'b1, v, 1'b1);
                cycle(1'b1, 24'h0, 1'b1);
            end
            drain();
            for (int f = 0; f < 6; f++) chk("saturate", {8'd0, lg(2*f)}, {8'd0, v});
        end

        // delay_len=0 behaves as 1 across the pointer wrap
        do_reset();
        mode = 2'b01; delay_len = 4'd0;
        for (int f = 0; f < 40; f++) begin
            cycle(1'b1, 24'h000100, 1'b1);
            cycle(1'b1, 24'($urandom), 1'b1);
        end
        drain();
        for (int f = 0; f < 40; f++) chk("dly0_wrap", {8'd0, lg(2*f)}, (f == 0) ? 32'h80 : 32'h100);

        // Longest delay: impulse returns after 15 frames
        do_reset();
        mode = 2'b01; delay_len = 4'd15;
        for (int f = 0; f < 20; f++) begin
            cycle(1'b1, (f == 0) ? 24'h400000 : 24'h0, 1'b1);
            cycle(1'b1, 24'h0, 1'b1);
        end
        drain();
        for (int f = 0; f < 20; f++)
            chk("dly15", {8'd0, lg(2*f)}, (f == 0 || f == 15) ? 32'h200000 : 32'h0);

        // Run-time parameter changes with random data (model-checked)
        do_reset();
        for (int i = 0; i < 60; i++) begin
            mode      = 2'($urandom_range(0, 3));
            delay_len = 4'($urandom_range(0, 15));
            fb_shift  = 3'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) != 0), 24'($urandom), 1'b1);
        end
        drain();

        // Reset mid-stream, then wren pulses during the clear
        do_reset();
        mode = 2'b01; delay_len = 4'd2;
        for (int i = 0; i < 10; i++) cycle(1'b1, 24'(i * 24'h1000), 1'b1);
        cycle(1'b1, 24'h111111, 1'b0);
        chk("valid_after_rst", {31'd0, out_valid}, 32'd0);
        n0 = log_d.size();
        zc = 0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) break;
            zc++;
            cycle(1'b1, 24'h123456, 1'b1);
        end
        chk("reclear_len", zc, 32);
        drain();
        chk("no_out_in_clear", log_d.size(), n0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 24'h000200, 1'b1);
        drain();
        chk("restart_chan", lgc(n0), 0);
        chk("restart_data", {8'd0, lg(n0)}, 32'h100);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
